// File: rtl/lsu.sv
// Load/store unit: steers stores onto byte lanes and extracts/extends loads over a valid/ready bus.
// Faults on misalignment, illegal size or bus timeout.
module lsu #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic        i_we,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic            we_q, we_d;
  logic            fault_q, fault_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic        misalign;
  logic        timed_out;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_mask;

  assign misalign = (i_size == 2'd3) ||
                    (i_size == 2'd1 && i_addr[0]) ||
                    (i_size == 2'd2 && i_addr[1:0] != 2'd0);

  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_MAX);

  assign shifted = i_mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ext = shifted;
    case (size_q)
      2'd0:    ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'd1:    ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    lane_wdata = i_wdata;
    lane_mask  = 4'b1111;
    case (i_size)
      2'd0: begin
        lane_wdata = {4{i_wdata[7:0]}};
        lane_mask  = 4'b0001;
      end
      2'd1: begin
        lane_wdata = {2{i_wdata[15:0]}};
        lane_mask  = 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wstrb_d = wstrb_q;
    size_d  = size_q;
    sign_d  = sign_q;
    we_d    = we_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          addr_d  = i_addr;
          wdata_d = lane_wdata;
          wstrb_d = i_we ? (lane_mask << i_addr[1:0]) : 4'b0000;
          size_d  = i_size;
          sign_d  = i_sign_ext;
          we_d    = i_we;
          fault_d = misalign;
          rdata_d = 32'h0;
          cnt_d   = '0;
          state_d = misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        // An accepted request must complete even if the timeout hits the same cycle.
        if (i_mem_ready) begin
          cnt_d   = '0;
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (timed_out) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          rdata_d = ext;
          state_d = S_DONE;
        end else if (timed_out) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wstrb_q <= wstrb_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      we_q    <= we_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_busy      = (state_q == S_REQ) || (state_q == S_WAIT);
  assign o_done      = (state_q == S_DONE);
  assign o_rdata     = o_done ? rdata_q : 32'h0;
  assign o_fault     = o_done ? fault_q : 1'b0;
  assign o_mem_valid = (state_q == S_REQ);
  assign o_mem_addr  = {addr_q[31:2], 2'b00};
  assign o_mem_we    = we_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wstrb = wstrb_q;

endmodule
